// File: rtl/video_timing_gen_8bits_if.sv
// Upstream pixel handshake between a pixel source and the video timing generator.
interface video_timing_gen_8bits_if;
    logic       pix_valid;
    logic [7:0] pix_data;
    logic       pix_ready;

    modport master (output pix_valid, output pix_data, input pix_ready);
    modport slave  (input pix_valid, input pix_data, output pix_ready);
endinterface

// File: rtl/video_timing_gen_8bits.sv
// Video timing generator: raster counters, sync/DE generation and a pixel
// pull interface with sticky underflow reporting.
// Optional feature macro: VIDEO_GEN_TEST_PATTERN_EN (XOR test pattern on pattern_sel).
module video_timing_gen_8bits #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter int unsigned SYNC_POL = 1
) (
    input  logic                           video_pclk,
    input  logic                           sys_rst,
    input  logic                           gen_en,
    video_timing_gen_8bits_if.slave        pix,
    input  logic                           pattern_sel,
    output logic                           post_video_vsync,
    output logic                           post_video_hsync,
    output logic                           post_video_de,
    output logic [7:0]                     post_video_data,
    output logic [9:0]                     post_video_xpos,
    output logic [9:0]                     post_video_ypos,
    output logic                           frame_start,
    output logic                           underflow
);

    localparam int unsigned H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned H_W          = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
    localparam int unsigned V_W          = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;
    localparam int unsigned H_SYNC_START = H_ACTIVE + H_FP;
    localparam int unsigned H_SYNC_END   = H_ACTIVE + H_FP + H_SYNC;
    localparam int unsigned V_SYNC_START = V_ACTIVE + V_FP;
    localparam int unsigned V_SYNC_END   = V_ACTIVE + V_FP + V_SYNC;
    localparam logic        SYNC_ACT     = (SYNC_POL != 0);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    state_t         state;
    logic [H_W-1:0] h_cnt;
    logic [V_W-1:0] v_cnt;

    logic       running;
    logic       active;
    logic       h_last;
    logic       v_last;
    logic       frame_wrap;
    logic       in_hsync;
    logic       in_vsync;
    logic       xfer;
    logic       starved;
    logic       pattern_on;
    logic [7:0] pattern_pix;

`ifdef VIDEO_GEN_TEST_PATTERN_EN
    // Test pattern replaces the upstream stream while selected.
    assign pattern_on  = pattern_sel;
    assign pattern_pix = 8'(h_cnt) ^ 8'(v_cnt);
`else
    logic unused_pattern_sel;
    assign unused_pattern_sel = pattern_sel;
    assign pattern_on         = 1'b0;
    assign pattern_pix        = 8'h00;
`endif

    // Raster decode of the current counter position.
    always_comb begin
        running    = (state != IDLE);
        active     = running && (32'(h_cnt) < H_ACTIVE) && (32'(v_cnt) < V_ACTIVE);
        h_last     = (h_cnt == H_W'(H_TOTAL - 1));
        v_last     = (v_cnt == V_W'(V_TOTAL - 1));
        frame_wrap = h_last && v_last;
        in_hsync   = (32'(h_cnt) >= H_SYNC_START) && (32'(h_cnt) < H_SYNC_END);
        in_vsync   = (32'(v_cnt) >= V_SYNC_START) && (32'(v_cnt) < V_SYNC_END);
        xfer       = active && !pattern_on && pix.pix_valid;
        starved    = active && !pattern_on && !pix.pix_valid;
    end

    // Pixels are pulled only during active video and never in pattern mode.
    assign pix.pix_ready = active && !pattern_on;

    // FSM, counters and registered video outputs (one cycle behind the counters).
    always_ff @(posedge video_pclk or posedge sys_rst) begin
        if (sys_rst) begin
            state            <= IDLE;
            h_cnt            <= '0;
            v_cnt            <= '0;
            post_video_de    <= 1'b0;
            post_video_hsync <= ~SYNC_ACT;
            post_video_vsync <= ~SYNC_ACT;
            post_video_data  <= 8'h00;
            post_video_xpos  <= 10'd0;
            post_video_ypos  <= 10'd0;
            frame_start      <= 1'b0;
            underflow        <= 1'b0;
        end else begin
            post_video_de    <= active;
            post_video_xpos  <= active ? 10'(h_cnt) : 10'd0;
            post_video_ypos  <= active ? 10'(v_cnt) : 10'd0;
            post_video_hsync <= (running && in_hsync) ? SYNC_ACT : ~SYNC_ACT;
            post_video_vsync <= (running && in_vsync) ? SYNC_ACT : ~SYNC_ACT;
            frame_start      <= active && (h_cnt == '0) && (v_cnt == '0);

            if (active && pattern_on) begin
                post_video_data <= pattern_pix;
            end else if (xfer) begin
                post_video_data <= pix.pix_data;
            end else begin
                post_video_data <= 8'h00;
            end

            case (state)
                IDLE: begin
                    h_cnt <= '0;
                    v_cnt <= '0;
                    if (gen_en) begin
                        state     <= RUN;
                        underflow <= 1'b0;
                    end
                end
                RUN, DRAIN: begin
                    if (h_last) begin
                        h_cnt <= '0;
                        v_cnt <= v_last ? '0 : v_cnt + V_W'(1);
                    end else begin
                        h_cnt <= h_cnt + H_W'(1);
                    end
                    // The gen_en value seen at the wrap cycle decides stop vs continue.
                    if (frame_wrap) begin
                        state <= gen_en ? RUN : IDLE;
                    end else if (state == RUN && !gen_en) begin
                        state <= DRAIN;
                    end
                end
                default: begin
                    state <= IDLE;
                    h_cnt <= '0;
                    v_cnt <= '0;
                end
            endcase

            // Sticky until reset or the next IDLE->RUN start.
            if (starved) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_video_timing_gen_8bits.sv
// Directed bench for video_timing_gen_8bits with a 7x6 raster (4x3 active).
module tb_video_timing_gen_8bits;

    localparam int HA = 4, HF = 1, HS = 1, HB = 1;
    localparam int VA = 3, VF = 1, VS = 1, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;

    logic       video_pclk = 1'b0;
    logic       sys_rst    = 1'b0;
    logic       gen_en     = 1'b0;
    logic       pattern_sel = 1'b0;
    logic       vsync, hsync, de, frame_start, underflow;
    logic [7:0] data;
    logic [9:0] xpos, ypos;
    logic [31:0] obs;

    int checks = 0;
    int errors = 0;

    video_timing_gen_8bits_if pix_bus ();

    video_timing_gen_8bits #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .SYNC_POL(1)
    ) dut (
        .video_pclk       (video_pclk),
        .sys_rst          (sys_rst),
        .gen_en           (gen_en),
        .pix              (pix_bus.slave),
        .pattern_sel      (pattern_sel),
        .post_video_vsync (vsync),
        .post_video_hsync (hsync),
        .post_video_de    (de),
        .post_video_data  (data),
        .post_video_xpos  (xpos),
        .post_video_ypos  (ypos),
        .frame_start      (frame_start),
        .underflow        (underflow)
    );

    always #5 video_pclk = ~video_pclk;

    assign obs = {de, hsync, vsync, frame_start, xpos, ypos, data};

    function automatic bit act(int h, int v);
        return (h < HA) && (v < VA);
    endfunction

    // Expected {de,hsync,vsync,frame_start,xpos,ypos,data} for a running raster position.
    function automatic logic [31:0] exp_vec(int h, int v, logic [7:0] d);
        bit a;
        a = act(h, v);
        return {a, 1'(h >= HA + HF && h < HA + HF + HS), 1'(v >= VA + VF && v < VA + VF + VS),
                1'(a && h == 0 && v == 0), a ? 10'(h) : 10'd0, a ? 10'(v) : 10'd0,
                a ? d : 8'h00};
    endfunction

    task automatic tick();
        @(posedge video_pclk);
        #1;
    endtask

    task automatic test_reset();
        pix_bus.pix_valid = 1'b0;
        pix_bus.pix_data  = 8'h00;
        #1 sys_rst = 1'b1;
        #1;
        checks++;
        if (obs !== 32'h0 || pix_bus.pix_ready !== 1'b0 || underflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_state obs=%h ready=%b uf=%b required obs=0 ready=0 uf=0",
                     obs, pix_bus.pix_ready, underflow);
        end
        tick();
        tick();
        checks++;
        if (obs !== 32'h0 || pix_bus.pix_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold obs=%h ready=%b required 0", obs, pix_bus.pix_ready);
        end
        sys_rst = 1'b0;
    endtask

    task automatic test_full_frame();
        int h, v, n_de, n_hs, n_vs, n_fs;
        logic [7:0] d;
        n_de = 0; n_hs = 0; n_vs = 0; n_fs = 0;
        d = 8'h20;
        gen_en = 1'b1;
        pix_bus.pix_valid = 1'b1;
        tick();
        for (int c = 0; c < HT * VT; c++) begin
            h = c % HT;
            v = c / HT;
            checks++;
            if (pix_bus.pix_ready !== act(h, v)) begin
                errors++;
                $display("FAIL frame_ready h=%0d v=%0d got %b required %b", h, v,
                         pix_bus.pix_ready, act(h, v));
            end
            pix_bus.pix_data = d;
            tick();
            checks++;
            if (obs !== exp_vec(h, v, d)) begin
                errors++;
                $display("FAIL frame_out h=%0d v=%0d got %h required %h", h, v, obs, exp_vec(h, v, d));
            end
            n_de += int'(de);
            n_hs += int'(hsync);
            n_vs += int'(vsync);
            n_fs += int'(frame_start);
            d = d + 8'h01;
        end
        checks++;
        if (n_de != 12 || n_hs != 6 || n_vs != 7 || n_fs != 1 || underflow !== 1'b0) begin
            errors++;
            $display("FAIL frame_counts de=%0d hs=%0d vs=%0d fs=%0d uf=%b required 12 6 7 1 0",
                     n_de, n_hs, n_vs, n_fs, underflow);
        end
    endtask

    task automatic test_underflow();
        int h, v;
        bit miss, uf;
        logic [7:0] d;
        uf = 1'b0;
        d = 8'h40;
        for (int c = 0; c < HT * VT; c++) begin
            h = c % HT;
            v = c / HT;
            miss = (h == 2 && v == 1);
            pix_bus.pix_valid = act(h, v) && !miss;
            pix_bus.pix_data  = d;
            tick();
            if (miss) uf = 1'b1;
            checks++;
            if (obs !== exp_vec(h, v, miss ? 8'h00 : d)) begin
                errors++;
                $display("FAIL uf_out h=%0d v=%0d got %h required %h", h, v, obs,
                         exp_vec(h, v, miss ? 8'h00 : d));
            end
            checks++;
            if (underflow !== uf) begin
                errors++;
                $display("FAIL uf_flag h=%0d v=%0d got %b required %b", h, v, underflow, uf);
            end
            d = d + 8'h01;
        end
        pix_bus.pix_valid = 1'b1;
    endtask

    task automatic test_stop();
        int h, v;
        logic [7:0] d;
        d = 8'h60;
        for (int c = 0; c < HT * VT; c++) begin
            h = c % HT;
            v = c / HT;
            if (c == HT) gen_en = 1'b0;
            pix_bus.pix_data = d;
            tick();
            checks++;
            if (obs !== exp_vec(h, v, d)) begin
                errors++;
                $display("FAIL stop_out h=%0d v=%0d got %h required %h", h, v, obs, exp_vec(h, v, d));
            end
            d = d + 8'h01;
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (pix_bus.pix_ready !== 1'b0) begin
                errors++;
                $display("FAIL stop_idle_ready cyc=%0d got %b required 0", i, pix_bus.pix_ready);
            end
            tick();
            checks++;
            if (obs !== 32'h0 || underflow !== 1'b1) begin
                errors++;
                $display("FAIL stop_idle_out cyc=%0d got obs=%h uf=%b required obs=0 uf=1",
                         i, obs, underflow);
            end
        end
    endtask

    task automatic test_back_to_back();
        int h, v;
        logic [7:0] d;
        d = 8'h80;
        gen_en = 1'b1;
        tick();
        checks++;
        if (underflow !== 1'b0) begin
            errors++;
            $display("FAIL restart_uf_clear got %b required 0", underflow);
        end
        for (int c = 0; c < HT * VT; c++) begin
            h = c % HT;
            v = c / HT;
            if (c == 2 * HT)     gen_en = 1'b0;
            if (c == 2 * HT + 1) gen_en = 1'b1;
            pix_bus.pix_data = d;
            tick();
            checks++;
            if (obs !== exp_vec(h, v, d)) begin
                errors++;
                $display("FAIL restart_out h=%0d v=%0d got %h required %h", h, v, obs, exp_vec(h, v, d));
            end
            d = d + 8'h01;
        end
        checks++;
        if (pix_bus.pix_ready !== 1'b1) begin
            errors++;
            $display("FAIL restart_no_idle ready got %b required 1", pix_bus.pix_ready);
        end
        pix_bus.pix_data = 8'hA5;
        tick();
        checks++;
        if (obs !== exp_vec(0, 0, 8'hA5)) begin
            errors++;
            $display("FAIL restart_first got %h required %h", obs, exp_vec(0, 0, 8'hA5));
        end
    endtask

    task automatic test_async_reset();
        repeat (8) tick();
        pix_bus.pix_valid = 1'b0;
        tick();
        pix_bus.pix_valid = 1'b1;
        checks++;
        if (de !== 1'b1 || xpos !== 10'd2 || ypos !== 10'd1 || underflow !== 1'b1) begin
            errors++;
            $display("FAIL arst_pre de=%b x=%0d y=%0d uf=%b required 1 2 1 1", de, xpos, ypos, underflow);
        end
        #2 sys_rst = 1'b1;
        #1;
        checks++;
        if (obs !== 32'h0 || pix_bus.pix_ready !== 1'b0 || underflow !== 1'b0) begin
            errors++;
            $display("FAIL arst_now obs=%h ready=%b uf=%b required 0 0 0", obs, pix_bus.pix_ready, underflow);
        end
        #1 sys_rst = 1'b0;
        tick();
        checks++;
        if (pix_bus.pix_ready !== 1'b1) begin
            errors++;
            $display("FAIL arst_restart_ready got %b required 1", pix_bus.pix_ready);
        end
        pix_bus.pix_data = 8'h3C;
        tick();
        checks++;
        if (obs !== exp_vec(0, 0, 8'h3C)) begin
            errors++;
            $display("FAIL arst_first got %h required %h", obs, exp_vec(0, 0, 8'h3C));
        end
    endtask

    task automatic test_pattern();
        int h, v;
        logic [7:0] d, ed;
        bit er;
        sys_rst = 1'b1;
        #1 sys_rst = 1'b0;
        pattern_sel = 1'b1;
`ifdef VIDEO_GEN_TEST_PATTERN_EN
        pix_bus.pix_valid = 1'b0;
`else
        pix_bus.pix_valid = 1'b1;
`endif
        d = 8'hC0;
        tick();
        for (int c = 0; c < HT * VT; c++) begin
            h = c % HT;
            v = c / HT;
`ifdef VIDEO_GEN_TEST_PATTERN_EN
            er = 1'b0;
            ed = 8'(h) ^ 8'(v);
`else
            er = act(h, v);
            ed = d;
`endif
            checks++;
            if (pix_bus.pix_ready !== er) begin
                errors++;
                $display("FAIL pattern_ready h=%0d v=%0d got %b required %b", h, v, pix_bus.pix_ready, er);
            end
            pix_bus.pix_data = d;
            tick();
            checks++;
            if (obs !== exp_vec(h, v, ed) || underflow !== 1'b0) begin
                errors++;
                $display("FAIL pattern_out h=%0d v=%0d got %h uf=%b required %h uf=0", h, v, obs,
                         underflow, exp_vec(h, v, ed));
            end
`ifdef VIDEO_GEN_TEST_PATTERN_EN
            if (h == 3 && v == 2) begin
                checks++;
                if (data !== 8'h01) begin
                    errors++;
                    $display("FAIL pattern_3_2 got %h required 01", data);
                end
            end
`endif
            d = d + 8'h01;
        end
        pattern_sel = 1'b0;
        pix_bus.pix_valid = 1'b1;
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_underflow();
        test_stop();
        test_back_to_back();
        test_async_reset();
        test_pattern();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/video_timing_gen_8bits.md
VIDEO_TIMING_GEN_8BITS -- requirements
Module: video_timing_gen_8bits

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640: active pixels per line.
REQ-002 SHALL have parameters H_FP/H_SYNC/H_BP, defaults 16/96/48: horizontal front porch, sync and back porch in pclk cycles.
REQ-003 SHALL have parameter V_ACTIVE, default 480: active lines per frame.
REQ-004 SHALL have parameters V_FP/V_SYNC/V_BP, defaults 10/2/33: vertical porches and sync, in lines.
REQ-005 SHALL have parameter SYNC_POL, default 1: 1 means sync pulses are active-high, 0 means active-low.
REQ-006 SHALL have port video_pclk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-007 SHALL have port sys_rst, input, 1 bit: reset, asynchronous, active-high.
REQ-008 SHALL have port gen_en, input, 1 bit: run request.
REQ-009 SHALL have ports pix_valid (input, 1), pix_data (input, 8) and pix_ready (output, 1): upstream pixel handshake.
REQ-010 SHALL have port pattern_sel, input, 1 bit: test-pattern select (see Configuration).
REQ-011 SHALL have ports post_video_vsync, post_video_hsync and post_video_de, each output, 1 bit.
REQ-012 SHALL have port post_video_data, output, 8 bits.
REQ-013 SHALL have ports post_video_xpos and post_video_ypos, each output, 10 bits.
REQ-014 SHALL have ports frame_start (output, 1) and underflow (output, 1): status.

Function
REQ-015 SHALL use states IDLE, RUN and DRAIN.
- IDLE -> RUN when gen_en=1.
- RUN -> DRAIN when gen_en=0.
- DRAIN -> IDLE at the frame wrap (h_cnt=H_TOTAL-1 and v_cnt=V_TOTAL-1).
- DRAIN -> RUN at the frame wrap if gen_en=1 again.
REQ-016 SHALL keep counters h_cnt (0..H_TOTAL-1) and v_cnt (0..V_TOTAL-1), where H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL is defined likewise.
- In IDLE, both counters SHALL hold at 0.
- In RUN and DRAIN, h_cnt SHALL increment every cycle.
- When h_cnt wraps, v_cnt SHALL increment; at V_TOTAL-1 it SHALL wrap to 0.
REQ-017 SHALL define active = (state!=IDLE) and h_cnt<H_ACTIVE and v_cnt<V_ACTIVE.
REQ-018 SHALL drive pix_ready = active, combinationally; a pixel transfers when pix_ready and pix_valid are both 1.
REQ-019 SHALL register all post_video_* outputs, with one cycle of latency from the counter values.
- post_video_de = active.
- post_video_xpos = h_cnt and post_video_ypos = v_cnt while active, otherwise 0.
- post_video_data = pix_data on a transfer, otherwise 0.
REQ-020 SHALL assert hsync (at SYNC_POL) for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
REQ-021 SHALL assert vsync (at SYNC_POL) for v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC), for the whole line.
REQ-022 SHALL hold both syncs inactive in IDLE.
REQ-023 SHALL pulse frame_start for one cycle, registered, coincident with the first de of each frame (xpos=0, ypos=0).
REQ-024 SHALL handle a missing pixel: when active=1 and pix_valid=0, post_video_de SHALL still be 1, post_video_data SHALL be 0, and underflow SHALL set sticky.
- underflow SHALL clear only on reset or on the IDLE->RUN transition.
REQ-025 SHALL leave pix_valid with no effect outside active cycles; no data is consumed then.
REQ-026 SHALL, when a gen_en deassert and a frame wrap occur in the same cycle, go to IDLE only if gen_en=0 at the wrap cycle.
REQ-027 SHALL size counters by the parameters; parameter limits are V_TOTAL<=1024 and H_TOTAL<=4096.

Reset
REQ-028 SHALL, on sys_rst=1, asynchronously force the following state: IDLE, h_cnt=0, v_cnt=0.
REQ-029 SHALL, on sys_rst=1, asynchronously force all outputs low with these exceptions:
- syncs go to their inactive level (~SYNC_POL).
- pix_ready=0, underflow=0 and frame_start=0.
REQ-030 SHALL, when reset occurs mid-frame, abandon the frame; the first frame after release starts at (0,0) once gen_en=1.

Configuration
REQ-031 SHALL, with VIDEO_GEN_TEST_PATTERN_EN defined and pattern_sel=1, output post_video_data = (h_cnt[7:0] XOR v_cnt[7:0]) on active cycles.
- pix_ready SHALL be 0 and underflow SHALL NOT update.
REQ-032 SHALL, without VIDEO_GEN_TEST_PATTERN_EN, ignore pattern_sel and instantiate no pattern logic.

Verification
All scenarios use small parameters: H_ACTIVE=4, H_FP=H_SYNC=H_BP=1, V_ACTIVE=3, V_FP=V_SYNC=V_BP=1, SYNC_POL=1.
REQ-033 SHALL cover a full frame: gen_en=1 with pix_valid=1 and incrementing data -> 12 de cycles with xpos 0..3 and ypos 0..2, H_TOTAL=7, one hsync cycle per line, vsync for line 4 (7 cycles), frame_start once.
REQ-034 SHALL cover underflow: pix_valid=0 at xpos=2, ypos=1 -> de=1, data=0 there, underflow=1 and held.
REQ-035 SHALL cover stop: gen_en drops mid-frame at ypos=1 -> frame completes to v_cnt=5, h_cnt=6; then IDLE with de=0 and syncs low.
REQ-036 SHALL cover async reset: sys_rst pulsed mid-line with no clock edge -> outputs are immediately at reset values; after release the next frame starts at (0,0).
REQ-037 SHALL cover the test pattern: with VIDEO_GEN_TEST_PATTERN_EN and pattern_sel=1 -> data at (3,2) = 8'h01, pix_ready=0 throughout.
REQ-038 SHALL cover restart: gen_en deasserted then reasserted before the wrap -> the next frame follows back-to-back with no IDLE cycle.
